dds_iq_correlator: RTL and testbench

- Consumer and controller for the COREDDS_C0 local oscillator in the GNSS test path.
- Sequences the DDS init handshake by driving INIT and waiting on INIT_OVER.
- Forwards host frequency-offset updates to the DDS.
- Mixes incoming signed ADC samples with the DDS SINE/COSINE outputs and integrates over a fixed window, emitting one I/Q accumulation pair per window.

---
 rtl/dds_corr_pkg.sv | 15 +
 rtl/dds_iq_correlator_iq_mac.sv | 53 +++++
 rtl/dds_iq_correlator.sv | 115 +++++++++++
 tb/tb_dds_iq_correlator.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dds_corr_pkg.sv
// dds_corr_pkg: shared FSM encoding and width defaults for dds_iq_correlator.
package dds_corr_pkg;

    typedef enum logic [1:0] {RESET_ST, INIT_REQ, INIT_WAIT, RUN} state_t;

    localparam int DEF_DATA_BITS  = 12;
    localparam int DEF_NCO_BITS   = 18;
    localparam int DEF_INTEG_LOG2 = 10;

    // Worst-case accumulator width: full product plus one bit per doubling of the window.
    function automatic int acc_bits(input int data_bits, input int nco_bits, input int integ_log2);
        return data_bits + nco_bits + integ_log2;
    endfunction

endpackage

// File: rtl/dds_iq_correlator_iq_mac.sv
// iq_mac: registered signed product (optionally negated) feeding a window accumulator.
module iq_mac #(
    parameter int DATA_BITS = 12,
    parameter int NCO_BITS  = 18,
    parameter int ACC_BITS  = 40,
    parameter bit NEG       = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic signed [DATA_BITS-1:0] a,
    input  logic signed [NCO_BITS-1:0]  b,
    output logic signed [ACC_BITS-1:0]  sum,
    output logic                       sum_valid
);
    localparam int PW = DATA_BITS + NCO_BITS;

    logic signed [PW-1:0] ax, bx, prod, p;
    logic signed [ACC_BITS-1:0] acc, nxt;
    logic v1, l1;

    assign ax   = PW'(a);
    assign bx   = PW'(b);
    assign prod = ax * bx;
    assign nxt  = acc + ACC_BITS'(p);

    // The window's last product is folded into sum while acc restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            v1        <= 1'b0;
            l1        <= 1'b0;
            acc       <= '0;
            sum       <= '0;
            sum_valid <= 1'b0;
        end else begin
            p         <= NEG ? -prod : prod;
            v1        <= in_valid & ~clr;
            l1        <= in_last;
            sum_valid <= v1 & l1 & ~clr;
            if (clr)
                acc <= '0;
            else if (v1) begin
                acc <= l1 ? '0 : nxt;
                if (l1)
                    sum <= nxt;
            end
        end
    end

endmodule

// File: rtl/dds_iq_correlator.sv
// dds_iq_correlator: COREDDS init/frequency sequencer and windowed I/Q correlator.
module dds_iq_correlator import dds_corr_pkg::*; #(
    parameter int DATA_BITS        = DEF_DATA_BITS,
    parameter int NCO_BITS         = DEF_NCO_BITS,
    parameter int FREQ_OFFSET_BITS = 3,
    parameter int INTEG_LOG2       = DEF_INTEG_LOG2,
    parameter int ACC_BITS         = acc_bits(DATA_BITS, NCO_BITS, INTEG_LOG2),
    parameter int INIT_TIMEOUT     = 4096
) (
    input  logic                        CLK,
    input  logic                        NGRST,
    input  logic                        restart,
    input  logic [FREQ_OFFSET_BITS-1:0] cfg_freq,
    input  logic                        cfg_freq_we,
    output logic                        dds_init,
    input  logic                        dds_init_over,
    output logic [FREQ_OFFSET_BITS-1:0] dds_freq,
    output logic                        dds_freq_we,
    input  logic signed [NCO_BITS-1:0]  dds_sin,
    input  logic signed [NCO_BITS-1:0]  dds_cos,
    input  logic                        s_valid,
    input  logic signed [DATA_BITS-1:0] s_data,
    output logic signed [ACC_BITS-1:0]  acc_i,
    output logic signed [ACC_BITS-1:0]  acc_q,
    output logic                        acc_valid,
    output logic                        running,
    output logic                        init_err
);
    localparam int TW = $clog2(INIT_TIMEOUT + 1);

    state_t state, state_nxt;
    logic [TW-1:0] tmo;
    logic [INTEG_LOG2-1:0] cnt;
    logic run, tmo_hit, clr, accept, last, pending, v_i, v_q;

    assign run         = state == RUN;
    assign tmo_hit     = state == INIT_WAIT && !dds_init_over && tmo == TW'(INIT_TIMEOUT - 1);
    assign dds_freq_we = run & pending;
    assign clr         = ~run | restart;
    assign accept      = run & s_valid & ~restart;
    assign last        = accept & (&cnt);
    assign acc_valid   = v_i & v_q;

    always_comb begin
        state_nxt = state;
        dds_init  = 1'b0;
        running   = 1'b0;
        case (state)
            RESET_ST:  state_nxt = INIT_REQ;
            INIT_REQ: begin
                dds_init  = 1'b1;
                state_nxt = INIT_WAIT;
            end
            INIT_WAIT: state_nxt = dds_init_over ? RUN : tmo_hit ? INIT_REQ : INIT_WAIT;
            default:   running = 1'b1;
        endcase
        if (restart)
            state_nxt = INIT_REQ;
    end

    // A write landing on the issue cycle re-arms pending so it goes out next cycle.
    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            state    <= RESET_ST;
            tmo      <= '0;
            init_err <= 1'b0;
            dds_freq <= '0;
            pending  <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            tmo      <= (state == INIT_WAIT && !tmo_hit && !restart) ? tmo + TW'(1) : '0;
            init_err <= init_err | tmo_hit;
            if (cfg_freq_we)
                dds_freq <= cfg_freq;
            pending  <= cfg_freq_we | (pending & ~dds_freq_we);
            cnt      <= clr ? '0 : cnt + INTEG_LOG2'(accept);
        end
    end

    iq_mac #(
        .DATA_BITS(DATA_BITS),
        .NCO_BITS (NCO_BITS),
        .ACC_BITS (ACC_BITS),
        .NEG      (1'b0)
    ) u_mac_i (
        .clk      (CLK),
        .rst_n    (NGRST),
        .clr      (clr),
        .in_valid (accept),
        .in_last  (last),
        .a        (s_data),
        .b        (dds_cos),
        .sum      (acc_i),
        .sum_valid(v_i)
    );

    iq_mac #(
        .DATA_BITS(DATA_BITS),
        .NCO_BITS (NCO_BITS),
        .ACC_BITS (ACC_BITS),
        .NEG      (1'b1)
    ) u_mac_q (
        .clk      (CLK),
        .rst_n    (NGRST),
        .clr      (clr),
        .in_valid (accept),
        .in_last  (last),
        .a        (s_data),
        .b        (dds_sin),
        .sum      (acc_q),
        .sum_valid(v_q)
    );

endmodule

// File: tb/tb_dds_iq_correlator.sv
// tb_dds_iq_correlator: directed checks of init sequencing, frequency writes and I/Q windows.
module tb_dds_iq_correlator;
    logic CLK = 1'b0, NGRST = 1'b0, restart = 1'b0, cfg_freq_we = 1'b0;
    logic dds_init_over = 1'b0, s_valid = 1'b0;
    logic [2:0] cfg_freq = '0;
    logic signed [17:0] dds_sin = '0, dds_cos = '0;
    logic signed [11:0] s_data = '0;
    logic dds_init, dds_freq_we, acc_valid, running, init_err;
    logic [2:0] dds_freq;
    logic signed [39:0] acc_i, acc_q, cap_i, cap_q;
    int tests = 0, fails = 0, pulses = 0, pulse_at = -1, n = 0;

    always #5 CLK = ~CLK;

    dds_iq_correlator dut (
        .CLK          (CLK),
        .NGRST        (NGRST),
        .restart      (restart),
        .cfg_freq     (cfg_freq),
        .cfg_freq_we  (cfg_freq_we),
        .dds_init     (dds_init),
        .dds_init_over(dds_init_over),
        .dds_freq     (dds_freq),
        .dds_freq_we  (dds_freq_we),
        .dds_sin      (dds_sin),
        .dds_cos      (dds_cos),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .acc_i        (acc_i),
        .acc_q        (acc_q),
        .acc_valid    (acc_valid),
        .running      (running),
        .init_err     (init_err)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents n consecutive samples, one per cycle, logging any acc_valid pulse seen meanwhile.
    task automatic feed(input int cnt, input logic signed [11:0] d, input logic signed [17:0] c,
                        input logic signed [17:0] sn);
        for (int i = 0; i < cnt; i++) begin
            s_valid = 1'b1; s_data = d; dds_cos = c; dds_sin = sn;
            @(negedge CLK);
            if (acc_valid) begin
                pulses++; pulse_at = i; cap_i = acc_i; cap_q = acc_q;
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin
        @(negedge CLK); @(negedge CLK);
        chk("rst_init", dds_init, 0);
        chk("rst_running", running, 0);
        chk("rst_err", init_err, 0);
        chk("rst_valid", acc_valid, 0);
        chk("rst_acc_i", acc_i, 0);
        chk("rst_acc_q", acc_q, 0);
        chk("rst_fwe", dds_freq_we, 0);
        chk("rst_freq", dds_freq, 0);
        NGRST = 1'b1;
        @(negedge CLK);
        chk("init_pulse", dds_init, 1);
        @(negedge CLK);
        chk("init_one_cycle", dds_init, 0);
        cfg_freq = 3'd3; cfg_freq_we = 1'b1;
        @(negedge CLK);
        cfg_freq_we = 1'b0;
        chk("freq_3", dds_freq, 3);
        chk("fwe_not_run", dds_freq_we, 0);
        cfg_freq = 3'd5; cfg_freq_we = 1'b1;
        @(negedge CLK);
        cfg_freq_we = 1'b0;
        chk("freq_5", dds_freq, 5);
        @(negedge CLK);
        chk("wait_no_init", dds_init, 0);
        chk("wait_not_run", running, 0);
        dds_init_over = 1'b1;
        @(negedge CLK);
        dds_init_over = 1'b0;
        chk("run_after_over", running, 1);
        chk("fwe_first_run", dds_freq_we, 1);
        chk("fwe_val", dds_freq, 5);
        chk("err_clear", init_err, 0);
        @(negedge CLK);
        chk("fwe_single", dds_freq_we, 0);

        cfg_freq = 3'd2; cfg_freq_we = 1'b1;
        @(negedge CLK);
        chk("fwe_run", dds_freq_we, 1);
        chk("freq_2", dds_freq, 2);
        cfg_freq = 3'd6;
        @(negedge CLK);
        cfg_freq_we = 1'b0;
        chk("fwe_again", dds_freq_we, 1);
        chk("freq_6", dds_freq, 6);
        @(negedge CLK);
        chk("fwe_done", dds_freq_we, 0);

        pulses = 0;
        feed(1024, 12'sd100, 18'sd1000, 18'sd0);
        chk("w1_no_early", pulses, 0);
        pulses = 0;
        feed(1024, -12'sd2048, 18'sd0, -18'sd131072);
        chk("w1_pulses", pulses, 1);
        chk("w1_latency", pulse_at, 0);
        chk("w1_i", cap_i, 102400000);
        chk("w1_q", cap_q, 0);
        @(negedge CLK);
        chk("w2_valid", acc_valid, 1);
        chk("w2_i", acc_i, 0);
        chk("w2_q", acc_q, -64'sd274877906944);
        @(negedge CLK);
        chk("w2_pulse_end", acc_valid, 0);
        chk("w2_hold", acc_q, -64'sd274877906944);

        pulses = 0;
        feed(500, 12'sd7, 18'sd3, 18'sd2);
        chk("rs_partial_none", pulses, 0);
        restart = 1'b1;
        @(negedge CLK);
        restart = 1'b0;
        chk("rs_init", dds_init, 1);
        chk("rs_running", running, 0);
        chk("rs_no_valid", acc_valid, 0);
        s_valid = 1'b1; s_data = 12'sd77; dds_cos = 18'sd77; dds_sin = 18'sd77;
        @(negedge CLK);
        dds_init_over = 1'b1;
        @(negedge CLK);
        dds_init_over = 1'b0;
        chk("rs_run", running, 1);
        chk("rs_hold_q", acc_q, -64'sd274877906944);
        chk("rs_hold_i", acc_i, 0);
        pulses = 0;
        feed(1024, 12'sd5, -18'sd1000, 18'sd300);
        chk("rs_no_early", pulses, 0);
        @(negedge CLK);
        chk("rs_valid", acc_valid, 1);
        chk("rs_i", acc_i, -5120000);
        chk("rs_q", acc_q, -1536000);

        restart = 1'b1;
        @(negedge CLK);
        restart = 1'b0;
        chk("to_init1", dds_init, 1);
        chk("to_err_before", init_err, 0);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!dds_init && n < 5000);
        chk("to_cycles", n, 4097);
        chk("to_err", init_err, 1);
        @(negedge CLK);
        chk("to_wait", dds_init, 0);
        dds_init_over = 1'b1;
        @(negedge CLK);
        dds_init_over = 1'b0;
        chk("to_run", running, 1);
        chk("to_err_sticky", init_err, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
